// File: rtl/hazard_pkg.sv
// Shared encodings and types for the pipeline hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY
  } mc_state_t;

  // Stall/flush bundle delivered to the pipeline registers.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic flush_d;
    logic flush_e;
    logic flush_m;
  } hazard_ctrl_t;

endpackage

// File: rtl/hazard_mc_timer.sv
// Occupancy timer for multi-cycle EX ops: stalls the pipe until the final
// EX cycle, then pulses done for that cycle.
module hazard_mc_timer
  import hazard_pkg::*;
#(
  parameter int unsigned MC_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_multi_cycle,
  output logic o_mc_stall,
  output logic o_mc_done
);

  localparam int unsigned CNT_W = $clog2(MC_LATENCY);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LATENCY - 2);

  mc_state_t        r_state;
  mc_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The IDLE entry cycle counts as the first stalled EX cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_mc_stall  = 1'b0;
    o_mc_done   = 1'b0;
    if (r_state == IDLE) begin
      if (i_multi_cycle) begin
        o_mc_stall  = 1'b1;
        w_state_nxt = BUSY;
        w_cnt_nxt   = CNT_INIT;
      end
    end else begin
      if (r_cnt != '0) begin
        o_mc_stall = 1'b1;
        w_cnt_nxt  = r_cnt - CNT_W'(1);
      end else begin
        o_mc_done   = 1'b1;
        w_state_nxt = IDLE;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: EX forwarding selects, load-use and branch
// handling, and multi-cycle EX sequencing for the 5-stage core.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned REG_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MultiCycleE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             McDone
);

  logic         w_mc_stall;
  logic         w_mc_done;
  logic         w_lw_stall;
  logic [1:0]   w_fwd_a;
  logic [1:0]   w_fwd_b;
  hazard_ctrl_t w_ctrl;

  hazard_mc_timer #(
    .MC_LATENCY (MC_LATENCY)
  ) u_mc_timer (
    .clk           (clk),
    .reset         (reset),
    .i_multi_cycle (MultiCycleE),
    .o_mc_stall    (w_mc_stall),
    .o_mc_done     (w_mc_done)
  );

  // MEM result is younger than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] rs,
    input logic             reg_write_m,
    input logic [REG_W-1:0] rd_m,
    input logic             reg_write_w,
    input logic [REG_W-1:0] rd_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  assign w_fwd_a = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign w_fwd_b = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

  assign w_lw_stall = (ResultSrcE == RESULTSRC_LOAD) && (RdE != '0) &&
                      ((Rs1D == RdE) || (Rs2D == RdE));

  // Multi-cycle stall dominates; a taken branch squashes the load-use bubble.
  always_comb begin
    w_ctrl = '0;
    if (w_mc_stall) begin
      w_ctrl.stall_f = 1'b1;
      w_ctrl.stall_d = 1'b1;
      w_ctrl.stall_e = 1'b1;
      w_ctrl.flush_m = 1'b1;
    end else if (PCSrcE) begin
      w_ctrl.flush_d = 1'b1;
      w_ctrl.flush_e = 1'b1;
    end else if (w_lw_stall) begin
      w_ctrl.stall_f = 1'b1;
      w_ctrl.stall_d = 1'b1;
      w_ctrl.flush_e = 1'b1;
    end
  end

  // Reset flushes every pipeline register and suppresses forwarding.
  always_comb begin
    StallF    = w_ctrl.stall_f;
    StallD    = w_ctrl.stall_d;
    StallE    = w_ctrl.stall_e;
    FlushD    = w_ctrl.flush_d;
    FlushE    = w_ctrl.flush_e;
    FlushM    = w_ctrl.flush_m;
    ForwardAE = w_fwd_a;
    ForwardBE = w_fwd_b;
    McDone    = w_mc_done;
    if (reset) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushM    = 1'b1;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      McDone    = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: MC_LATENCY=4 main instance plus an
// MC_LATENCY=2 instance for the short-latency sweep.
module tb_hazard_ctrl_unit;

  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       sf;
    logic       sd;
    logic       se;
    logic       fd;
    logic       fe;
    logic       fm;
    logic       md;
    logic       se2;
    logic       md2;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [REG_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]       ResultSrcE;
  logic             RegWriteM, RegWriteW, PCSrcE, MultiCycleE, mc2;

  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, McDone;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF2, StallD2, StallE2, FlushD2, FlushE2, FlushM2, McDone2;
  logic [1:0] ForwardAE2, ForwardBE2;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.MC_LATENCY(4), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
    .FlushM(FlushM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .McDone(McDone)
  );

  hazard_ctrl_unit #(.MC_LATENCY(2), .REG_W(REG_W)) dut2 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MultiCycleE(mc2),
    .StallF(StallF2), .StallD(StallD2), .StallE(StallE2), .FlushD(FlushD2), .FlushE(FlushE2),
    .FlushM(FlushM2), .ForwardAE(ForwardAE2), .ForwardBE(ForwardBE2), .McDone(McDone2)
  );

  function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb,
                              input logic sf, input logic sd, input logic se,
                              input logic fd, input logic fe, input logic fm,
                              input logic md, input logic se2, input logic md2);
    exp_t e;
    e.fa = fa; e.fb = fb; e.sf = sf; e.sd = sd; e.se = se;
    e.fd = fd; e.fe = fe; e.fm = fm; e.md = md; e.se2 = se2; e.md2 = md2;
    return e;
  endfunction

  // Monitor: outputs settle half a cycle after stimulus; pop and compare on negedge.
  always @(negedge clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
            McDone, StallE2, McDone2};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got fa=%b fb=%b sf%b sd%b se%b fd%b fe%b fm%b md%b se2%b md2%b, want fa=%b fb=%b sf%b sd%b se%b fd%b fe%b fm%b md%b se2%b md2%b",
                 nm, a.fa, a.fb, a.sf, a.sd, a.se, a.fd, a.fe, a.fm, a.md, a.se2, a.md2,
                 e.fa, e.fb, e.sf, e.sd, e.se, e.fd, e.fe, e.fm, e.md, e.se2, e.md2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic clear_inputs();
    reset = 1'b0;
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = 2'b00; RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
    MultiCycleE = 1'b0; mc2 = 1'b0;
  endtask

  initial begin
    exp_t rst_v;
    exp_t zero_v;
    rst_v  = mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    zero_v = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);

    tick(); reset = 1'b1;
    expect_v("reset", rst_v);

    tick(); reset = 1'b0;
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd3;
    expect_v("fwd_mem_prio", mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(); RegWriteM = 1'b0;
    expect_v("fwd_wb", mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(); RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0;
    expect_v("fwd_x0", zero_v);
    tick(); Rs2E = 5'd9; RdW = 5'd9; RdM = 5'd4;
    expect_v("fwd_b_wb", mk(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    tick(); clear_inputs(); ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    expect_v("lw_stall", mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    tick(); ResultSrcE = 2'b00;
    expect_v("lw_one_cycle", zero_v);
    tick(); ResultSrcE = 2'b01; RdE = 5'd0; Rs2D = 5'd0;
    expect_v("lw_x0", zero_v);

    tick(); RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
    expect_v("br_masks_lw", mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 0));

    tick(); clear_inputs(); MultiCycleE = 1'b1; mc2 = 1'b1;
    expect_v("mc_c0", mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 1, 0));
    tick();
    expect_v("mc_c1", mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 0, 1));
    tick();
    expect_v("mc_c2", mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 1, 0));
    tick();
    expect_v("mc_c3_done", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    tick();
    expect_v("mc_c4_b2b", mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 1, 0));
    tick();
    expect_v("mc_c5", mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 0, 1));
    tick(); PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    expect_v("mc_c6_masks_br_lw", mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 1, 0));
    tick(); clear_inputs(); MultiCycleE = 1'b1; mc2 = 1'b1;
    expect_v("mc_c7_done", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    tick(); clear_inputs();
    expect_v("mc_idle", zero_v);

    tick(); MultiCycleE = 1'b1;
    expect_v("rmid_start", mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 0, 0));
    tick(); reset = 1'b1; MultiCycleE = 1'b0; RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5;
    expect_v("rmid_reset", rst_v);
    tick(); clear_inputs();
    expect_v("rmid_idle", zero_v);
    tick();
    expect_v("rmid_no_done", zero_v);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
